// File: rtl/axi_stream_packet_source_if.sv
// AXI4-Stream bus between the packet source (master) and its sink (slave).
// Widths are set by the instantiating context and must match the source's parameters.
interface axi_stream_packet_source_if #(
    parameter int unsigned byte_width = 4,
    parameter int unsigned id_width   = 2
) ();
    logic                    tvalid;
    logic                    tready;
    logic [8*byte_width-1:0] tdata;
    logic [byte_width-1:0]   tkeep;
    logic [byte_width-1:0]   tstrb;
    logic                    tlast;
    logic [id_width-1:0]     tid;

    modport master (
        output tvalid, tdata, tkeep, tstrb, tlast, tid,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tkeep, tstrb, tlast, tid,
        output tready
    );
endinterface

// File: rtl/axi_stream_packet_source.sv
// AXI4-Stream packet generator: one incrementing-byte packet of programmable length per start.
// Every output comes straight from a flop; tready only steers next-state logic.
module axi_stream_packet_source #(
    parameter int unsigned byte_width  = 4,
    parameter int unsigned len_width   = 12,
    parameter int unsigned id_width    = 2,
    parameter int unsigned count_width = 16
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   start,
    input  logic [len_width-1:0]   start_len,
    input  logic [7:0]             start_seed,
    input  logic [id_width-1:0]    start_id,
    output logic                   busy,
    output logic [count_width-1:0] pkt_count,
    axi_stream_packet_source_if.master axis
);
    localparam int unsigned          data_width = 8 * byte_width;
    localparam logic [len_width-1:0] bw_len     = len_width'(byte_width);
    localparam logic [7:0]           bw_byte    = 8'(byte_width);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                 state_q, state_d;
    logic                   tvalid_q, tvalid_d;
    logic                   tlast_q, tlast_d;
    logic [data_width-1:0]  tdata_q, tdata_d;
    logic [byte_width-1:0]  tkeep_q, tkeep_d;
    logic [id_width-1:0]    tid_q, tid_d;
    logic                   busy_q, busy_d;
    logic [count_width-1:0] cnt_q, cnt_d;
    logic [7:0]             base_q, base_d;
    logic [len_width-1:0]   rem_q, rem_d;

    logic                   hs;
    logic [7:0]             gen_base;
    logic [len_width-1:0]   gen_rem;
    logic [data_width-1:0]  gen_data;
    logic [byte_width-1:0]  gen_keep;
    logic                   gen_last;

    assign hs = tvalid_q && axis.tready;

    // Next beat to load: beat 0 of a new packet in IDLE, else the beat after the current one
    always_comb begin
        gen_base = start_seed;
        gen_rem  = start_len;
        if (state_q == SEND) begin
            gen_base = base_q + bw_byte;
            gen_rem  = rem_q - bw_len;
        end
    end

    // rem counts bytes left including this beat; lanes past it are unqualified and zero
    always_comb begin
        gen_data = '0;
        gen_keep = '0;
        for (int i = 0; i < int'(byte_width); i++) begin
            if (32'(i) < 32'(gen_rem)) begin
                gen_keep[i]        = 1'b1;
                gen_data[8*i +: 8] = gen_base + 8'(i);
            end
        end
        gen_last = (32'(gen_rem) <= 32'(byte_width));
    end

    always_comb begin
        state_d  = state_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        tdata_d  = tdata_q;
        tkeep_d  = tkeep_q;
        tid_d    = tid_q;
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        base_d   = base_q;
        rem_d    = rem_q;

        unique case (state_q)
            IDLE: begin
                if (start && (start_len != '0)) begin
                    state_d  = SEND;
                    tvalid_d = 1'b1;
                    busy_d   = 1'b1;
                    tid_d    = start_id;
                    base_d   = gen_base;
                    rem_d    = gen_rem;
                    tdata_d  = gen_data;
                    tkeep_d  = gen_keep;
                    tlast_d  = gen_last;
                end
            end
            SEND: begin
                if (hs) begin
                    if (tlast_q) begin
                        state_d  = IDLE;
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        busy_d   = 1'b0;
                        tdata_d  = '0;
                        tkeep_d  = '0;
                        cnt_d    = cnt_q + count_width'(1);
                    end else begin
                        base_d  = gen_base;
                        rem_d   = gen_rem;
                        tdata_d = gen_data;
                        tkeep_d = gen_keep;
                        tlast_d = gen_last;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tdata_q  <= '0;
            tkeep_q  <= '0;
            tid_q    <= '0;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            base_q   <= '0;
            rem_q    <= '0;
        end else begin
            state_q  <= state_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            tdata_q  <= tdata_d;
            tkeep_q  <= tkeep_d;
            tid_q    <= tid_d;
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            base_q   <= base_d;
            rem_q    <= rem_d;
        end
    end

    assign axis.tvalid = tvalid_q;
    assign axis.tdata  = tdata_q;
    assign axis.tkeep  = tkeep_q;
    assign axis.tstrb  = tkeep_q;
    assign axis.tlast  = tlast_q;
    assign axis.tid    = tid_q;
    assign busy        = busy_q;
    assign pkt_count   = cnt_q;
endmodule

// File: tb/tb_axi_stream_packet_source.sv
// Directed bench for axi_stream_packet_source: byte_width=4, count_width=2 so the counter wraps.
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
module tb_axi_stream_packet_source;
    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic [11:0] start_len;
    logic [7:0]  start_seed;
    logic [1:0]  start_id;
    logic        busy;
    logic [1:0]  pkt_count;

    int n_checks = 0;
    int n_fail   = 0;
    logic [1:0]  exp_cnt;
    logic [31:0] cap_data [8];
    logic [3:0]  cap_keep [8];
    logic        cap_last [8];

    axi_stream_packet_source_if #(.byte_width(4), .id_width(2)) axis ();

    axi_stream_packet_source #(
        .byte_width(4), .len_width(12), .id_width(2), .count_width(2)
    ) dut (
        .clk(clk), .resetn(resetn), .start(start), .start_len(start_len),
        .start_seed(start_seed), .start_id(start_id), .busy(busy),
        .pkt_count(pkt_count), .axis(axis)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference beat contents for a packet of len bytes starting at seed
    function automatic void model(input int len, input logic [7:0] seed, input int b,
                                  output logic [31:0] d, output logic [3:0] k, output logic l);
        d = '0;
        k = '0;
        for (int i = 0; i < 4; i++) begin
            if (b*4 + i < len) begin
                k[i]        = 1'b1;
                d[8*i +: 8] = seed + 8'(b*4 + i);
            end
        end
        l = ((b + 1) * 4 >= len);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Caller is 1 unit after a posedge. stall_beat<0 means no backpressure.
    task automatic run_pkt(input int len, input logic [7:0] seed, input logic [1:0] id,
                           input int stall_beat, input int stall_cycles, input bit dup);
        int nb;
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
        nb = (len + 3) / 4;
        check("pre_valid", 64'(axis.tvalid), 64'd0);
        start = 1'b1; start_len = 12'(len); start_seed = seed; start_id = id;
        axis.tready = 1'b1;
        step();
        for (int b = 0; b < nb; b++) begin
            model(len, seed, b, d, k, l);
            if (dup && b == 0) begin
                start = 1'b1; start_len = 12'd4; start_seed = 8'h55; start_id = 2'd3;
            end
            if (b == stall_beat) begin
                axis.tready = 1'b0;
                for (int s = 0; s < stall_cycles; s++) begin
                    @(negedge clk);
                    check($sformatf("stall%0d_valid", s), 64'(axis.tvalid), 64'd1);
                    check($sformatf("stall%0d_data", s), 64'(axis.tdata), 64'(d));
                    check($sformatf("stall%0d_keep", s), 64'(axis.tkeep), 64'(k));
                    check($sformatf("stall%0d_last", s), 64'(axis.tlast), 64'(l));
                    step();
                end
                axis.tready = 1'b1;
            end
            @(negedge clk);
            check($sformatf("b%0d_valid", b), 64'(axis.tvalid), 64'd1);
            check($sformatf("b%0d_data", b), 64'(axis.tdata), 64'(d));
            check($sformatf("b%0d_keep", b), 64'(axis.tkeep), 64'(k));
            check($sformatf("b%0d_strb", b), 64'(axis.tstrb), 64'(k));
            check($sformatf("b%0d_last", b), 64'(axis.tlast), 64'(l));
            check($sformatf("b%0d_tid", b), 64'(axis.tid), 64'(id));
            check($sformatf("b%0d_busy", b), 64'(busy), 64'd1);
            cap_data[b] = axis.tdata;
            cap_keep[b] = axis.tkeep;
            cap_last[b] = axis.tlast;
            step();
        end
        exp_cnt = exp_cnt + 2'd1;
        check("end_valid", 64'(axis.tvalid), 64'd0);
        check("end_busy", 64'(busy), 64'd0);
        check("end_count", 64'(pkt_count), 64'(exp_cnt));
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; start_len = '0; start_seed = '0; start_id = '0;
        axis.tready = 1'b0;
        exp_cnt = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 64'(axis.tvalid), 64'd0);
        check("rst_last", 64'(axis.tlast), 64'd0);
        check("rst_data", 64'(axis.tdata), 64'd0);
        check("rst_keep", 64'(axis.tkeep), 64'd0);
        check("rst_strb", 64'(axis.tstrb), 64'd0);
        check("rst_tid", 64'(axis.tid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_count", 64'(pkt_count), 64'd0);
        @(posedge clk); #1; resetn = 1'b1;
        step();
        check("idle_valid", 64'(axis.tvalid), 64'd0);

        // Two full beats
        run_pkt(8, 8'h10, 2'd1, -1, 0, 1'b0);
        check("l8_b0_data", 64'(cap_data[0]), 64'h13121110);
        check("l8_b1_data", 64'(cap_data[1]), 64'h17161514);
        check("l8_b0_keep", 64'(cap_keep[0]), 64'hF);
        check("l8_b1_keep", 64'(cap_keep[1]), 64'hF);
        check("l8_b0_last", 64'(cap_last[0]), 64'd0);
        check("l8_b1_last", 64'(cap_last[1]), 64'd1);
        check("l8_count", 64'(pkt_count), 64'd1);

        // Partial final beat
        run_pkt(5, 8'h10, 2'd0, -1, 0, 1'b0);
        check("l5_b0_data", 64'(cap_data[0]), 64'h13121110);
        check("l5_b1_data", 64'(cap_data[1]), 64'h00000014);
        check("l5_b1_keep", 64'(cap_keep[1]), 64'h1);
        check("l5_b1_last", 64'(cap_last[1]), 64'd1);

        // Backpressure for 3 cycles on the second beat
        run_pkt(12, 8'h20, 2'd2, 1, 3, 1'b0);
        check("stall_b1_data", 64'(cap_data[1]), 64'h27262524);
        check("stall_b2_data", 64'(cap_data[2]), 64'h2B2A2928);

        // Zero-length start is ignored
        start = 1'b1; start_len = 12'd0; start_seed = 8'h33;
        step();
        check("len0_busy", 64'(busy), 64'd0);
        check("len0_valid", 64'(axis.tvalid), 64'd0);
        step();
        check("len0_valid2", 64'(axis.tvalid), 64'd0);
        check("len0_count", 64'(pkt_count), 64'd3);

        // Start during an active packet is dropped; 4th packet wraps the counter
        run_pkt(8, 8'h80, 2'd2, -1, 0, 1'b1);
        check("wrap_count", 64'(pkt_count), 64'd0);
        step();
        check("dup_valid", 64'(axis.tvalid), 64'd0);
        check("dup_busy", 64'(busy), 64'd0);
        step();
        check("dup_valid2", 64'(axis.tvalid), 64'd0);

        // Payload byte wrap inside a single beat
        run_pkt(4, 8'hFE, 2'd3, -1, 0, 1'b0);
        check("fe_data", 64'(cap_data[0]), 64'h0100FFFE);
        check("fe_last", 64'(cap_last[0]), 64'd1);
        check("fe_keep", 64'(cap_keep[0]), 64'hF);

        // Asynchronous reset on beat 2 of 4
        start = 1'b1; start_len = 12'd16; start_seed = 8'h40; start_id = 2'd1;
        axis.tready = 1'b1;
        step();
        step();
        step();
        axis.tready = 1'b0;
        check("mid_valid", 64'(axis.tvalid), 64'd1);
        check("mid_data", 64'(axis.tdata), 64'h4B4A4948);
        #2 resetn = 1'b0;
        #1;
        check("arst_valid", 64'(axis.tvalid), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_count", 64'(pkt_count), 64'd0);
        check("arst_last", 64'(axis.tlast), 64'd0);
        exp_cnt = '0;
        @(posedge clk); #1; resetn = 1'b1; axis.tready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("post_rst_valid%0d", c), 64'(axis.tvalid), 64'd0);
            check($sformatf("post_rst_busy%0d", c), 64'(busy), 64'd0);
        end

        run_pkt(3, 8'h00, 2'd0, -1, 0, 1'b0);
        check("post_rst_data", 64'(cap_data[0]), 64'h00020100);
        check("post_rst_keep", 64'(cap_keep[0]), 64'h7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
